// File: rtl/apb_slave_regfile.sv
// Zero-wait APB register file with an APB phase-sequencing monitor.
// Optional status register at word DEPTH is built only when APB_SLV_STATUS_EN is defined.
module apb_slave_regfile #(
  parameter int unsigned SEL_IDX   = 0,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 Hclk,
  input  logic                 Hreset,
  input  logic [2:0]           Pselx,
  input  logic                 Penable,
  input  logic                 Pwrite,
  input  logic [31:0]          Paddr,
  input  logic [31:0]          Pwdata,
  output logic [31:0]          Prdata,
  output logic                 proto_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [15:0]          wr_cnt
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                 state_q;
  logic [31:0]            mem_q [DEPTH];
  logic [31:0]            addr_q;
  logic                   wr_q;
  logic [31:0]            prdata_q;
  logic                   proto_q;
  logic [ERR_CNT_W-1:0]   err_q;
  logic [15:0]            wrc_q;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  logic          sel;
  logic          setup_cyc;
  logic          access_cyc;
  logic [31:0]   cur_off;
  logic [31:0]   lat_off;
  logic          cur_hit;
  logic          lat_hit;
  logic          cur_stat;
  logic [AW-1:0] cur_idx;
  logic [AW-1:0] lat_idx;
  logic [31:0]   rd_val;
  logic          unused_sel;

  assign sel        = Pselx[SEL_IDX];
  assign unused_sel = ^Pselx;

  // A setup is any selected cycle without Penable; an access must follow a SETUP state.
  assign setup_cyc  = sel && !Penable;
  assign access_cyc = (state_q == SETUP) && sel && Penable;

  assign cur_off = Paddr - BASE_ADDR;
  assign lat_off = addr_q - BASE_ADDR;
  assign cur_hit = (Paddr[1:0] == 2'b00) && (cur_off < SPAN);
  assign lat_hit = (addr_q[1:0] == 2'b00) && (lat_off < SPAN);
  assign cur_idx = cur_off[AW+1:2];
  assign lat_idx = lat_off[AW+1:2];

`ifdef APB_SLV_STATUS_EN
  logic        lat_stat;
  logic [31:0] status_word;
  assign cur_stat    = (Paddr[1:0] == 2'b00) && (cur_off == SPAN);
  assign lat_stat    = (addr_q[1:0] == 2'b00) && (lat_off == SPAN);
  assign status_word = {wrc_q, 15'(err_q), proto_q};
`else
  assign cur_stat    = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    if (cur_hit) rd_val = mem_q[cur_idx];
`ifdef APB_SLV_STATUS_EN
    if (cur_stat) rd_val = status_word;
`endif
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      prdata_q <= '0;
      proto_q  <= 1'b0;
      err_q    <= '0;
      wrc_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      prdata_q <= '0;

      case (state_q)
        IDLE: begin
          if (sel && !Penable) state_q <= SETUP;
          else if (sel && Penable) proto_q <= 1'b1;
        end
        SETUP: begin
          if (sel && Penable) begin
            state_q <= ACCESS;
          end else begin
            proto_q <= 1'b1;
            state_q <= (sel && !Penable) ? SETUP : IDLE;
          end
        end
        ACCESS: begin
          if (!sel) state_q <= IDLE;
          else if (!Penable) state_q <= SETUP;
          else proto_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase

      if (setup_cyc) begin
        addr_q <= Paddr;
        wr_q   <= Pwrite;
        if (!Pwrite) begin
          prdata_q <= rd_val;
          if (!cur_hit && !cur_stat) err_q <= sat_inc(err_q);
        end
      end

      // The access completes from the latched address even if the bus wobbled.
      if (access_cyc) begin
        if ((Paddr != addr_q) || (Pwrite != wr_q)) proto_q <= 1'b1;
        if (wr_q) begin
`ifdef APB_SLV_STATUS_EN
          if (lat_stat) begin
            if (Pwdata[0]) proto_q <= 1'b0;
            if (Pwdata[1]) err_q   <= '0;
          end else
`endif
          if (lat_hit) begin
            mem_q[lat_idx] <= Pwdata;
            wrc_q          <= wrc_q + 16'd1;
          end else begin
            err_q <= sat_inc(err_q);
          end
        end
      end
    end
  end

  assign Prdata    = prdata_q;
  assign proto_err = proto_q;
  assign err_cnt   = err_q;
  assign wr_cnt    = wrc_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile: expected read data queued at setup, compared in access.
module tb_apb_slave_regfile;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 16;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        proto_err;
  logic [7:0]  err_cnt;
  logic [15:0] wr_cnt;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] m_mem [DEPTH];
  logic        m_proto;
  logic [7:0]  m_err;
  logic [15:0] m_wr;
  logic [2:0]  sel_pat = 3'b001;

  always #5 Hclk = ~Hclk;

  apb_slave_regfile #(
    .SEL_IDX(0), .BASE_ADDR(BASE), .DEPTH(DEPTH), .ERR_CNT_W(8)
  ) dut (
    .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata),
    .proto_err(proto_err), .err_cnt(err_cnt), .wr_cnt(wr_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Hclk);
    #1;
  endtask

  task automatic bus_idle;
    Pselx   = 3'b000;
    Penable = 1'b0;
    tick();
  endtask

  task automatic mdl_reset;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_proto = 1'b0;
    m_err   = '0;
    m_wr    = '0;
    exp_q.delete();
  endtask

  task automatic err_inc;
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endtask

  // 0 = miss, 1 = register, 2 = status word
  function automatic int mdl_kind(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (a[1:0] != 2'b00) return 0;
    if (off < 32'(DEPTH * 4)) return 1;
`ifdef APB_SLV_STATUS_EN
    if (off == 32'(DEPTH * 4)) return 2;
`endif
    return 0;
  endfunction

  task automatic chk_status;
    check("proto_err", 32'(proto_err), 32'(m_proto));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
    check("wr_cnt", 32'(wr_cnt), 32'(m_wr));
  endtask

  task automatic do_reset;
    Hreset = 1'b1; Pselx = 3'b000; Penable = 1'b0;
    tick();
    Hreset = 1'b0;
    mdl_reset();
  endtask

  // Setup + access with no trailing idle, so calls chain back-to-back.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    int          k;
    logic [31:0] off;
    logic [31:0] e;
    k   = mdl_kind(addr);
    off = addr - BASE;
    Pselx = sel_pat; Penable = 1'b0; Pwrite = wr; Paddr = addr; Pwdata = data;
    if (!wr) begin
      if (k == 1)      e = m_mem[off[5:2]];
      else if (k == 2) e = {m_wr, 7'd0, m_err, m_proto};
      else begin
        e = '0;
        err_inc();
      end
      exp_q.push_back(e);
    end
    tick();
    if (!wr) begin
      if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
      else check("rdata", Prdata, exp_q.pop_front());
    end
    Penable = 1'b1;
    tick();
    if (wr) begin
      if (k == 1) begin
        m_mem[off[5:2]] = data;
        m_wr = m_wr + 16'd1;
      end else if (k == 2) begin
        if (data[0]) m_proto = 1'b0;
        if (data[1]) m_err = '0;
      end else begin
        err_inc();
      end
    end
    check("rdata_zero", Prdata, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    Hreset = 1'b1; Pselx = 3'b111; Penable = 1'b1; Pwrite = 1'b1;
    Paddr = BASE; Pwdata = 32'hFFFF_FFFF;
    mdl_reset();
    tick(); tick();
    check("rst_prdata", Prdata, 32'd0);
    chk_status();
    Hreset = 1'b0;
    Pselx = 3'b000; Penable = 1'b0;
    tick();

    // Write then read back-to-back.
    xfer(1'b1, BASE + 32'd8, 32'hDEAD_BEEF);
    xfer(1'b0, BASE + 32'd8, 32'd0);
    bus_idle();
    check("raw_wr_cnt", 32'(wr_cnt), 32'd1);
    check("raw_proto", 32'(proto_err), 32'd0);

    for (int i = 0; i < DEPTH; i++) xfer(1'b1, BASE + 32'(4 * i), $urandom);
    for (int i = 0; i < DEPTH; i++) xfer(1'b0, BASE + 32'(4 * i), 32'd0);
    bus_idle();
    chk_status();

    // Other select bits alone must be ignored; multi-hot including ours is legal.
    Pselx = 3'b110; Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE; Pwdata = 32'h5555_5555;
    tick();
    Penable = 1'b1;
    tick();
    bus_idle();
    xfer(1'b0, BASE, 32'd0);
    sel_pat = 3'b111;
    xfer(1'b1, BASE + 32'd12, 32'hCAFE_F00D);
    xfer(1'b0, BASE + 32'd12, 32'd0);
    sel_pat = 3'b001;
    bus_idle();
    chk_status();

    // Decode misses.
    xfer(1'b0, BASE + 32'(DEPTH * 4), 32'd0);
    bus_idle();
    chk_status();
    xfer(1'b1, BASE + 32'd2, 32'h1111_2222);
    xfer(1'b0, BASE - 32'd4, 32'd0);
    bus_idle();
    chk_status();

    repeat (40) begin
      a = BASE + 32'(4 * $urandom_range(0, DEPTH + 3));
      if ($urandom_range(0, 7) == 0) a = a + 32'd1;
      xfer(1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 1) == 1) bus_idle();
    end
    bus_idle();
    chk_status();

    // Enable without setup from idle; flag stays set across legal traffic.
    Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'b0; Paddr = BASE;
    tick();
    m_proto = 1'b1;
    check("proto_nosetup", 32'(proto_err), 32'd1);
    bus_idle();
    for (int i = 0; i < 10; i++) xfer(1'(i % 2), BASE + 32'(4 * (i % DEPTH)), $urandom);
    bus_idle();
    chk_status();

    // Setup abandoned without access.
    do_reset();
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE;
    tick();
    Pselx = 3'b000;
    tick();
    m_proto = 1'b1;
    chk_status();

    // Enable held past the access: flag set, no second commit.
    do_reset();
    xfer(1'b1, BASE + 32'd4, 32'hAAAA_0001);
    Pwdata = 32'hBBBB_0002;
    tick();
    m_proto = 1'b1;
    bus_idle();
    xfer(1'b0, BASE + 32'd4, 32'd0);
    bus_idle();
    chk_status();

    // Address changes between setup and access.
    do_reset();
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE + 32'd4; Pwdata = 32'h1234;
    tick();
    Penable = 1'b1; Paddr = BASE + 32'd8;
    tick();
    m_mem[1] = 32'h1234; m_wr = 16'd1; m_proto = 1'b1;
    bus_idle();
    chk_status();
    xfer(1'b0, BASE + 32'd4, 32'd0);
    xfer(1'b0, BASE + 32'd8, 32'd0);
    bus_idle();

    // Reset lands on the access of a write.
    xfer(1'b1, BASE + 32'd16, 32'h7777_8888);
    bus_idle();
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE; Pwdata = 32'hFFFF_FFFF;
    tick();
    Penable = 1'b1; Hreset = 1'b1;
    tick();
    Hreset = 1'b0; Pselx = 3'b000; Penable = 1'b0;
    mdl_reset();
    check("rst_mid_prdata", Prdata, 32'd0);
    chk_status();
    xfer(1'b0, BASE, 32'd0);
    xfer(1'b0, BASE + 32'd16, 32'd0);
    bus_idle();
    chk_status();

    // Error counter saturation.
    Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'b0; Paddr = BASE;
    tick();
    m_proto = 1'b1;
    bus_idle();
    for (int i = 0; i < 300; i++) xfer(1'b0, BASE + 32'd2, 32'd0);
    bus_idle();
    check("err_sat", 32'(err_cnt), 32'hFF);
    chk_status();
`ifdef APB_SLV_STATUS_EN
    xfer(1'b0, BASE + 32'(DEPTH * 4), 32'd0);
    xfer(1'b1, BASE + 32'(DEPTH * 4), 32'd3);
    check("stat_clr_err", 32'(err_cnt), 32'd0);
    check("stat_clr_proto", 32'(proto_err), 32'd0);
    chk_status();
    bus_idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
